explore_harness: RTL and testbench
==================================

Name: explore_harness

Overview:
- Generic, parametrised operand-loading and result-capture harness for area-exploration DUTs (adder, mult, fma, and others).
- Bit-serially loads N operand lanes and snapshots them into a stable operand register on a start pulse.
- Presents operands to an external DUT, waits a configurable pipeline latency, then captures or XOR-accumulates the result.
- The result is read back a byte at a time through a narrow output port. Sits between the tile pad logic and the DUT instance.

Parameters:
- WIDTH, 8, operand width per lane (1..32).
- NUM_OPERANDS, 3, number of serial operand lanes (1..4).
- LATENCY, 0, DUT pipeline depth in cycles from operand valid to result valid (0..15).
- RESULT_WIDTH, 16, significant DUT result bits (1..32).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global advance; low freezes the FSM, counter, shift lanes and result register.
- ser_in  in  NUM_OPERANDS  serial bit per lane.
- shift_en  in  1  shift ser_in into the lanes this cycle.
- start  in  1  launch one DUT evaluation.
- acc_mode  in  1  0 = load result, 1 = XOR-accumulate result.
- byte_sel  in  2  selects the result byte on dout.
- dut_ops  out  NUM_OPERANDS*WIDTH  snapshotted operands; lane i at [i*WIDTH +: WIDTH].
- dut_valid  out  1  one-cycle pulse in the first RUN cycle.
- dut_enable  out  1  equals enable.
- dut_result  in  RESULT_WIDTH  DUT output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- dout  out  8  selected byte of result_q.

Behaviour:
- Reset, synchronous: lanes, op_q, result_q and cnt are 0; state is IDLE; busy, done, dut_valid and dout are 0.
- Lanes: with enable && shift_en, lane[i] <= {lane[i][WIDTH-2:0], ser_in[i]}.
  - The first bit shifted becomes the MSB after WIDTH shifts; older bits are dropped.
  - Lanes shift in every state; they are independent of the FSM.
- FSM states are IDLE, RUN and DONE. All transitions and updates are gated by enable.
  - IDLE or DONE with start: op_q <= lanes (value before any same-cycle shift), cnt <= LATENCY, go to RUN.
  - RUN with cnt != 0: cnt <= cnt-1.
  - RUN with cnt == 0: capture the result, go to DONE.
  - RUN with start: start is ignored; there is no queueing.
  - DONE without start: stay in DONE. DONE with start: re-launch (same as IDLE); done drops the next cycle.
- Latency: with start sampled at edge t0, the capture happens at edge t0+LATENCY+1 and done is high from that edge. busy is high for exactly LATENCY+1 cycles.
- dut_valid is high only in the cycle after the start edge (the first RUN cycle). If enable is low in that cycle, dut_valid stays high until enable returns.
- Capture:
  - acc_mode=0: result_q <= zero-extended dut_result.
  - acc_mode=1: result_q <= result_q ^ zero-extended dut_result.
  - acc_mode is sampled at the capture edge only.
- dout = result_q[8*byte_sel +: 8], combinational from registers. Bytes above RESULT_WIDTH read as 0.
- enable low mid-RUN: cnt, state and result_q hold; the latency count resumes when enable returns.
- reset mid-RUN: immediate return to IDLE, no capture, result_q cleared.
- Simultaneous start and shift_en: op_q takes the pre-shift lane values.

Decomposition:
- Package explore_pkg:
  - state enum {IDLE, RUN, DONE}.
  - MAX_RESULT_WIDTH = 32.
  - CNT_W = 4.
  - Byte-index constants.
- One sub-module, explore_shift_lane (WIDTH): a single serial lane with enable and shift.
  - Instantiated NUM_OPERANDS times in a generate loop.
  - FSM, capture and readback mux stay in explore_harness.

Test Plan (bench DUT model is a combinational or LATENCY-delayed adder of lanes 0 and 1):
- WIDTH=8, LATENCY=2. Shift 0xA5 into lane0 and 0x3C into lane1 (MSB first, 8 cycles), pulse start.
  - busy for 3 cycles, dut_valid 1 cycle, done at t0+3.
  - byte_sel=0 gives dout=0xE1; byte_sel=1 gives 0x00; byte_sel=3 gives 0x00.
- LATENCY=0, operands 0xFF and 0x01.
  - done at t0+1; byte0=0x00, byte1=0x01 (carry visible).
- acc_mode=1 over two runs with results 0x00F0 then 0x0F0F.
  - After the first run result_q=0x00F0; after the second 0x0FFF.
- start held in RUN plus shift_en active.
  - No relaunch; op_q unchanged; lanes still shift.
- enable low for 5 cycles mid-RUN (LATENCY=3).
  - Capture delayed by exactly 5 cycles; result correct.
- reset asserted in RUN.
  - Next cycle IDLE, busy=0, done=0, dout=0, no dut_valid.
  - A later start behaves as a fresh run.

Source files
------------

// File: rtl/explore_pkg.sv
// rtl/explore_pkg.sv - shared types and constants for the exploration harness
package explore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_RESULT_WIDTH = 32;
    localparam int CNT_W            = 4;

    localparam logic [1:0] BYTE_0 = 2'd0;
    localparam logic [1:0] BYTE_1 = 2'd1;
    localparam logic [1:0] BYTE_2 = 2'd2;
    localparam logic [1:0] BYTE_3 = 2'd3;

endpackage

// File: rtl/explore_shift_lane.sv
// rtl/explore_shift_lane.sv - one serial operand lane, first bit in ends up as MSB
module explore_shift_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] lane
);

    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane <= '0;
                end else if (enable && shift_en) begin
                    lane <= ser_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane <= '0;
                end else if (enable && shift_en) begin
                    lane <= {lane[WIDTH-2:0], ser_in};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/explore_harness.sv
// rtl/explore_harness.sv - serial operand loader, latency timer and result capture for a DUT
module explore_harness
    import explore_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_OPERANDS = 3,
    parameter int LATENCY      = 0,
    parameter int RESULT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_OPERANDS-1:0]       ser_in,
    input  logic                          shift_en,
    input  logic                          start,
    input  logic                          acc_mode,
    input  logic [1:0]                    byte_sel,
    output logic [NUM_OPERANDS*WIDTH-1:0] dut_ops,
    output logic                          dut_valid,
    output logic                          dut_enable,
    input  logic [RESULT_WIDTH-1:0]       dut_result,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    dout
);

    logic [NUM_OPERANDS*WIDTH-1:0] lanes;
    logic [NUM_OPERANDS*WIDTH-1:0] op_q;
    logic [MAX_RESULT_WIDTH-1:0]   result_q;
    logic [MAX_RESULT_WIDTH-1:0]   result_ext;
    logic [CNT_W-1:0]              cnt;
    state_e                        state;
    logic                          launch;

    for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_lane
        explore_shift_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .shift_en (shift_en),
            .ser_in   (ser_in[i]),
            .lane     (lanes[i*WIDTH +: WIDTH])
        );
    end

    // A start seen while RUN is dropped; there is no pending-launch queue.
    assign launch     = enable && start && (state != ST_RUN);
    assign result_ext = MAX_RESULT_WIDTH'(dut_result);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            dut_valid <= 1'b0;
        end else if (enable) begin
            // Held across a frozen first RUN cycle so the DUT never misses it.
            dut_valid <= launch;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q  <= lanes;
                        cnt   <= CNT_W'(LATENCY);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        result_q <= acc_mode ? (result_q ^ result_ext) : result_ext;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dut_ops    = op_q;
    assign dut_enable = enable;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign dout       = result_q[{byte_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_explore_harness.sv
// tb/tb_explore_harness.sv - directed bench for explore_harness at latencies 0, 2 and 3
module tb_explore_harness;
    import explore_pkg::*;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int RW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, shift_en, start, acc_mode;
    logic [N-1:0]  ser_in;
    logic [1:0]    byte_sel;
    logic          ovr_en;
    logic [RW-1:0] ovr_val;

    logic [N*W-1:0] ops_l0, ops_l2, ops_l3;
    logic [RW-1:0]  res_l0, res_l2, res_l3;
    logic           val_l0, val_l2, val_l3;
    logic           den_l0, den_l2, den_l3;
    logic           busy_l0, busy_l2, busy_l3;
    logic           done_l0, done_l2, done_l3;
    logic [7:0]     dout_l0, dout_l2, dout_l3;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference DUT: 16-bit sum of lanes 0 and 1, optionally overridden by the bench.
    assign res_l0 = ovr_en ? ovr_val : ({8'h00, ops_l0[7:0]} + {8'h00, ops_l0[15:8]});
    assign res_l2 = ovr_en ? ovr_val : ({8'h00, ops_l2[7:0]} + {8'h00, ops_l2[15:8]});
    assign res_l3 = ovr_en ? ovr_val : ({8'h00, ops_l3[7:0]} + {8'h00, ops_l3[15:8]});

    explore_harness #(.WIDTH(W), .NUM_OPERANDS(N), .LATENCY(0), .RESULT_WIDTH(RW)) u_l0 (
        .clk(clk), .reset(reset), .enable(enable), .ser_in(ser_in), .shift_en(shift_en),
        .start(start), .acc_mode(acc_mode), .byte_sel(byte_sel), .dut_ops(ops_l0),
        .dut_valid(val_l0), .dut_enable(den_l0), .dut_result(res_l0), .busy(busy_l0),
        .done(done_l0), .dout(dout_l0));

    explore_harness #(.WIDTH(W), .NUM_OPERANDS(N), .LATENCY(2), .RESULT_WIDTH(RW)) u_l2 (
        .clk(clk), .reset(reset), .enable(enable), .ser_in(ser_in), .shift_en(shift_en),
        .start(start), .acc_mode(acc_mode), .byte_sel(byte_sel), .dut_ops(ops_l2),
        .dut_valid(val_l2), .dut_enable(den_l2), .dut_result(res_l2), .busy(busy_l2),
        .done(done_l2), .dout(dout_l2));

    explore_harness #(.WIDTH(W), .NUM_OPERANDS(N), .LATENCY(3), .RESULT_WIDTH(RW)) u_l3 (
        .clk(clk), .reset(reset), .enable(enable), .ser_in(ser_in), .shift_en(shift_en),
        .start(start), .acc_mode(acc_mode), .byte_sel(byte_sel), .dut_ops(ops_l3),
        .dut_valid(val_l3), .dut_enable(den_l3), .dut_result(res_l3), .busy(busy_l3),
        .done(done_l3), .dout(dout_l3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic shift_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 7; i >= 0; i--) begin
            ser_in   = {c[i], b[i], a[i]};
            shift_en = 1'b1;
            tick;
        end
        shift_en = 1'b0;
        ser_in   = '0;
    endtask

    task automatic launch;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_l0;
            2:       return done_l2;
            default: return done_l3;
        endcase
    endfunction

    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (!done_of(sel) && n < 50) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; shift_en = 1'b1; ser_in = '1;
        tick;
        tick;
        start = 1'b0; shift_en = 1'b0; ser_in = '0;
        n_cmp++; if (busy_l2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy_l2); end
        n_cmp++; if (done_l2 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done_l2); end
        n_cmp++; if (val_l2 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", val_l2); end
        n_cmp++; if (ops_l2 !== 24'h0) begin n_bad++; $display("FAIL reset_ops got %h want 000000", ops_l2); end
        for (int b = 0; b < 4; b++) begin
            byte_sel = 2'(b);
            #1;
            n_cmp++; if (dout_l2 !== 8'h00) begin n_bad++; $display("FAIL reset_dout%0d got %h want 00", b, dout_l2); end
        end
        reset = 1'b0;
        byte_sel = BYTE_0;
        tick;
    endtask

    task automatic test_latency2;
        int n, nb, nv;
        do_reset;
        shift_ops(8'hA5, 8'h3C, 8'h00);
        launch;
        n_cmp++; if (ops_l2[15:0] !== 16'h3CA5) begin n_bad++; $display("FAIL l2_ops got %h want 3ca5", ops_l2[15:0]); end
        n = 0; nb = 0; nv = 0;
        while (!done_l2 && n < 50) begin
            if (busy_l2) nb++;
            if (val_l2) nv++;
            tick;
            n++;
        end
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL l2_done_latency got %0d want 3", n); end
        n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL l2_busy_cycles got %0d want 3", nb); end
        n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL l2_valid_cycles got %0d want 1", nv); end
        n_cmp++; if (busy_l2 !== 1'b0) begin n_bad++; $display("FAIL l2_busy_at_done got %0b want 0", busy_l2); end
        byte_sel = BYTE_0; #1;
        n_cmp++; if (dout_l2 !== 8'hE1) begin n_bad++; $display("FAIL l2_byte0 got %h want e1", dout_l2); end
        byte_sel = BYTE_1; #1;
        n_cmp++; if (dout_l2 !== 8'h00) begin n_bad++; $display("FAIL l2_byte1 got %h want 00", dout_l2); end
        byte_sel = BYTE_3; #1;
        n_cmp++; if (dout_l2 !== 8'h00) begin n_bad++; $display("FAIL l2_byte3 got %h want 00", dout_l2); end
        byte_sel = BYTE_0;
    endtask

    task automatic test_latency0;
        int n;
        do_reset;
        shift_ops(8'hFF, 8'h01, 8'h00);
        launch;
        n_cmp++; if (val_l0 !== 1'b1) begin n_bad++; $display("FAIL l0_valid got %0b want 1", val_l0); end
        n_cmp++; if (busy_l0 !== 1'b1) begin n_bad++; $display("FAIL l0_busy got %0b want 1", busy_l0); end
        wait_done(0, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL l0_done_latency got %0d want 1", n); end
        byte_sel = BYTE_0; #1;
        n_cmp++; if (dout_l0 !== 8'h00) begin n_bad++; $display("FAIL l0_byte0 got %h want 00", dout_l0); end
        byte_sel = BYTE_1; #1;
        n_cmp++; if (dout_l0 !== 8'h01) begin n_bad++; $display("FAIL l0_byte1_carry got %h want 01", dout_l0); end
        byte_sel = BYTE_0;
    endtask

    task automatic test_acc;
        int n;
        do_reset;
        ovr_en = 1'b1; ovr_val = 16'h00F0; acc_mode = 1'b1;
        launch;
        wait_done(2, n);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL acc1_latency got %0d want 3", n); end
        byte_sel = BYTE_0; #1;
        n_cmp++; if (dout_l2 !== 8'hF0) begin n_bad++; $display("FAIL acc1_byte0 got %h want f0", dout_l2); end
        byte_sel = BYTE_1; #1;
        n_cmp++; if (dout_l2 !== 8'h00) begin n_bad++; $display("FAIL acc1_byte1 got %h want 00", dout_l2); end
        ovr_val = 16'h0F0F;
        launch;
        n_cmp++; if (done_l2 !== 1'b0 || busy_l2 !== 1'b1) begin n_bad++; $display("FAIL relaunch_from_done got done=%0b busy=%0b want done=0 busy=1", done_l2, busy_l2); end
        wait_done(2, n);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL acc2_latency got %0d want 3", n); end
        byte_sel = BYTE_0; #1;
        n_cmp++; if (dout_l2 !== 8'hFF) begin n_bad++; $display("FAIL acc2_byte0 got %h want ff", dout_l2); end
        byte_sel = BYTE_1; #1;
        n_cmp++; if (dout_l2 !== 8'h0F) begin n_bad++; $display("FAIL acc2_byte1 got %h want 0f", dout_l2); end
        byte_sel = BYTE_0;
        ovr_en = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic test_start_in_run;
        int n;
        do_reset;
        shift_ops(8'h11, 8'h22, 8'h33);
        launch;
        start = 1'b1; shift_en = 1'b1; ser_in = 3'b111;
        tick;
        tick;
        n_cmp++; if (ops_l3 !== 24'h332211) begin n_bad++; $display("FAIL run_ops_stable got %h want 332211", ops_l3); end
        n_cmp++; if (val_l3 !== 1'b0) begin n_bad++; $display("FAIL run_no_relaunch_valid got %0b want 0", val_l3); end
        start = 1'b0; shift_en = 1'b0; ser_in = '0;
        wait_done(3, n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL run_no_relaunch_latency got %0d want 2", n); end
        n_cmp++; if (dout_l3 !== 8'h33) begin n_bad++; $display("FAIL run_result got %h want 33", dout_l3); end
        // Same-edge start and shift: the snapshot must take the pre-shift lanes.
        start = 1'b1; shift_en = 1'b1; ser_in = 3'b000;
        tick;
        start = 1'b0; shift_en = 1'b0;
        n_cmp++; if (ops_l3 !== 24'hCF8B47) begin n_bad++; $display("FAIL preshift_ops got %h want cf8b47", ops_l3); end
        wait_done(3, n);
        n_cmp++; if (dout_l3 !== 8'hD2) begin n_bad++; $display("FAIL preshift_result got %h want d2", dout_l3); end
    endtask

    task automatic test_enable_freeze;
        int n;
        do_reset;
        shift_ops(8'h10, 8'h20, 8'h00);
        launch;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++; if (busy_l3 !== 1'b1 || val_l3 !== 1'b1 || den_l3 !== 1'b0) begin n_bad++; $display("FAIL freeze_hold%0d got busy=%0b valid=%0b den=%0b want 1 1 0", i, busy_l3, val_l3, den_l3); end
        end
        enable = 1'b1;
        tick;
        n_cmp++; if (val_l3 !== 1'b0) begin n_bad++; $display("FAIL freeze_valid_drop got %0b want 0", val_l3); end
        wait_done(3, n);
        n_cmp++; if (n + 6 !== 9) begin n_bad++; $display("FAIL freeze_latency got %0d want 9", n + 6); end
        n_cmp++; if (dout_l3 !== 8'h30) begin n_bad++; $display("FAIL freeze_result got %h want 30", dout_l3); end
    endtask

    task automatic test_reset_in_run;
        int n;
        logic bad;
        shift_ops(8'h05, 8'h06, 8'h00);
        launch;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++; if (busy_l3 !== 1'b0 || done_l3 !== 1'b0 || val_l3 !== 1'b0) begin n_bad++; $display("FAIL rst_run_state got busy=%0b done=%0b valid=%0b want 0 0 0", busy_l3, done_l3, val_l3); end
        n_cmp++; if (dout_l3 !== 8'h00) begin n_bad++; $display("FAIL rst_run_dout got %h want 00", dout_l3); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done_l3 || val_l3 || busy_l3) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rst_run_quiet got %0b want 0", bad); end
        shift_ops(8'h07, 8'h09, 8'h00);
        launch;
        n_cmp++; if (val_l3 !== 1'b1) begin n_bad++; $display("FAIL fresh_valid got %0b want 1", val_l3); end
        wait_done(3, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL fresh_latency got %0d want 4", n); end
        n_cmp++; if (dout_l3 !== 8'h10) begin n_bad++; $display("FAIL fresh_result got %h want 10", dout_l3); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; shift_en = 1'b0; start = 1'b0; acc_mode = 1'b0;
        ser_in = '0; byte_sel = BYTE_0; ovr_en = 1'b0; ovr_val = '0;
        test_reset;
        test_latency2;
        test_latency0;
        test_acc;
        test_start_in_run;
        test_enable_freeze;
        test_reset_in_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
